// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_loader
//  Description : Streams layer weights from a valid/ready source into the
//                per-neuron weight memories (one-hot wen, shared addr/data).
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_loader #(
    parameter int NUM_NEURON = 30,
    parameter int NUM_WEIGHT = 30,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT),
    parameter int NIDX_WIDTH = $clog2(NUM_NEURON)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [NUM_NEURON-1:0] mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_wadd,
    output logic [DATA_WIDTH-1:0] mem_win,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_W_LAST = ADDR_WIDTH'(NUM_WEIGHT - 1);
    localparam logic [NIDX_WIDTH-1:0] c_N_LAST = NIDX_WIDTH'(NUM_NEURON - 1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_w_idx;
    logic [NIDX_WIDTH-1:0] r_n_idx;
    logic [NUM_NEURON-1:0] r_wen;
    logic [ADDR_WIDTH-1:0] r_wadd;
    logic [DATA_WIDTH-1:0] r_win;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_w_wrap;
    logic                  w_final;
    logic [NUM_NEURON-1:0] w_onehot;

    assign w_ready  = (r_state == c_LOAD);
    assign w_accept = s_valid & w_ready;
    assign w_w_wrap = (r_w_idx == c_W_LAST);
    assign w_final  = w_w_wrap && (r_n_idx == c_N_LAST);

    // Neuron index to write-enable decode; an out-of-range index yields no enable.
    generate
        for (genvar n = 0; n < NUM_NEURON; n++) begin : g_wen_dec
            assign w_onehot[n] = (r_n_idx == NIDX_WIDTH'(n));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_w_idx <= '0;
            r_n_idx <= '0;
            r_wen   <= '0;
            r_wadd  <= '0;
            r_win   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wen  <= '0;
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_LOAD;
                        r_busy  <= 1'b1;
                        r_w_idx <= '0;
                        r_n_idx <= '0;
                        r_err   <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        r_wen  <= w_onehot;
                        r_wadd <= r_w_idx;
                        r_win  <= s_data;
                        if (w_w_wrap) begin
                            r_w_idx <= '0;
                            r_n_idx <= r_n_idx + 1'b1;
                        end else begin
                            r_w_idx <= r_w_idx + 1'b1;
                        end
                        // Framing: s_last must coincide exactly with the final beat.
                        if (w_final) begin
                            r_busy <= 1'b0;
                            if (s_last) begin
                                r_state <= c_DONE;
                            end else begin
                                r_state <= c_IDLE;
                                r_err   <= 1'b1;
                            end
                        end else if (s_last) begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready  = w_ready;
    assign mem_wen  = r_wen;
    assign mem_wadd = r_wadd;
    assign mem_win  = r_win;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_loader
//  Description : Directed, scoreboard-checked bench for weight_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

    localparam int NN = 30;
    localparam int NW = 30;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int TOTAL = NN * NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic [NN-1:0] mem_wen;
    logic [AW-1:0] mem_wadd;
    logic [DW-1:0] mem_win;
    logic          busy;
    logic          done;
    logic          err;

    weight_loader #(
        .NUM_NEURON (NN),
        .NUM_WEIGHT (NW),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NIDX_WIDTH (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .mem_wen  (mem_wen),
        .mem_wadd (mem_wadd),
        .mem_win  (mem_win),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    logic [NN-1:0] q_wen  [$];
    logic [AW-1:0] q_wadd [$];
    logic [DW-1:0] q_win  [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT presents a write.
    task automatic observe();
        logic [NN-1:0] e_wen;
        logic [AW-1:0] e_wadd;
        logic [DW-1:0] e_win;
        if (done === 1'b1) n_done++;
        if (mem_wen !== '0) begin
            if (q_wen.size() == 0) begin
                chk("unexpected_write", 64'(mem_wen), 64'(0));
            end else begin
                e_wen  = q_wen.pop_front();
                e_wadd = q_wadd.pop_front();
                e_win  = q_win.pop_front();
                chk("wr_wen",  64'(mem_wen),  64'(e_wen));
                chk("wr_wadd", 64'(mem_wadd), 64'(e_wadd));
                chk("wr_win",  64'(mem_win),  64'(e_win));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic send_beat(input int k, input logic last, input logic acc);
        logic [NN-1:0] one;
        one     = NN'(1);
        s_valid = 1'b1;
        s_data  = DW'(k);
        s_last  = last;
        chk("s_ready", 64'(s_ready), 64'(acc));
        if (acc) begin
            q_wen.push_back(one << (k / NW));
            q_wadd.push_back(AW'(k % NW));
            q_win.push_back(DW'(k));
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic gap();
        tick();
        chk("gap_wen", 64'(mem_wen), 64'(0));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy",  64'(busy),    64'(1));
        chk("start_ready", 64'(s_ready), 64'(1));
        chk("start_err",   64'(err),     64'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"},  64'(s_ready),  64'(0));
        chk({tag, "_mem_wen"},  64'(mem_wen),  64'(0));
        chk({tag, "_mem_wadd"}, 64'(mem_wadd), 64'(0));
        chk({tag, "_mem_win"},  64'(mem_win),  64'(0));
        chk({tag, "_busy"},     64'(busy),     64'(0));
        chk({tag, "_done"},     64'(done),     64'(0));
        chk({tag, "_err"},      64'(err),      64'(0));
    endtask

    // Called on the cycle the final write is visible.
    task automatic finish_ok(input int done_before);
        chk("fin_done_wr", 64'(done), 64'(0));
        chk("fin_err",     64'(err),  64'(0));
        chk("fin_busy",    64'(busy), 64'(0));
        tick();
        chk("fin_done_pulse", 64'(done), 64'(1));
        tick();
        chk("fin_done_low", 64'(done),    64'(0));
        chk("fin_ready",    64'(s_ready), 64'(0));
        chk("fin_done_cnt", 64'(n_done - done_before), 64'(1));
        chk("fin_sb_empty", 64'(q_wen.size()), 64'(0));
    endtask

    initial begin
        int d0;
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("reset");

        // Full back-to-back load, including the neuron wrap at beats 29/30
        d0 = n_done;
        do_start();
        for (int k = 0; k < TOTAL; k++) send_beat(k, (k == TOTAL - 1), 1'b1);
        finish_ok(d0);

        // Same stream with valid pattern 1,0,0
        d0 = n_done;
        do_start();
        for (int k = 0; k < TOTAL; k++) begin
            send_beat(k, (k == TOTAL - 1), 1'b1);
            if (k != TOTAL - 1) begin
                gap();
                gap();
            end
        end
        finish_ok(d0);

        // Early s_last on beat 45
        d0 = n_done;
        do_start();
        for (int k = 0; k <= 45; k++) send_beat(k, (k == 45), 1'b1);
        chk("early_err",  64'(err),  64'(1));
        chk("early_busy", 64'(busy), 64'(0));
        send_beat(46, 1'b0, 1'b0);
        send_beat(47, 1'b0, 1'b0);
        chk("early_err_sticky", 64'(err), 64'(1));
        chk("early_no_done", 64'(n_done - d0), 64'(0));
        chk("early_sb_empty", 64'(q_wen.size()), 64'(0));
        do_start();

        // Missing s_last: reuse the load just started
        d0 = n_done;
        for (int k = 0; k < TOTAL; k++) send_beat(k, 1'b0, 1'b1);
        chk("miss_err",  64'(err),  64'(1));
        chk("miss_busy", 64'(busy), 64'(0));
        tick();
        tick();
        chk("miss_ready",   64'(s_ready), 64'(0));
        chk("miss_no_done", 64'(n_done - d0), 64'(0));
        chk("miss_sb_empty", 64'(q_wen.size()), 64'(0));

        // Reset mid-load after beat 100, with a beat offered alongside rst
        do_start();
        for (int k = 0; k <= 100; k++) send_beat(k, 1'b0, 1'b1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = DW'(101);
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        check_reset_vals("midrst");
        tick();
        check_reset_vals("midrst_idle");
        do_start();
        for (int k = 0; k < 3; k++) send_beat(k, 1'b0, 1'b1);
        tick();
        chk("reload_sb_empty", 64'(q_wen.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
